// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side sequencer for the multicycle datapath.
// Takes one fetch/load/store request at a time, strobes a synchronous word
// memory with a fixed read latency, latches fetched words into ir and loaded
// words into mdr, and returns a one-cycle done (and err) pulse to control.
module mem_access_unit #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_IR    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic        iord,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] jaddr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [3:0]  r_cnt;

    logic [31:0] w_addr;
    logic        w_bad;

    // Address mux and request legality, evaluated only while idle.
    always_comb begin
        w_addr = iord ? alu_out : pc;
        w_bad  = (w_addr[1:0] != 2'b00) || (op == OP_RSVD);
    end

    // Access sequencer: all outputs are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_FETCH;
            r_cnt     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            ir        <= RESET_IR;
            mdr       <= 32'h0;
        end else begin
            // NOTE: pulse outputs default low every cycle so no state can leave one stuck high.
            done   <= 1'b0;
            err    <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        r_op <= op;
                        if (w_bad) begin
                            r_state <= S_ERR;
                        end else begin
                            // Strobe is registered here so it is high exactly in the ACCESS cycle.
                            r_state   <= S_ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= (op == OP_STORE);
                            mem_addr  <= w_addr;
                            mem_wdata <= wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= LAT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter reaches 1 in the cycle mem_rdata is valid.
                    if (r_cnt == 4'd1) begin
                        if (r_op == OP_FETCH) begin
                            ir <= mem_rdata;
                        end else if (r_op == OP_LOAD) begin
                            mdr <= mem_rdata;
                        end
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Requests seen here are dropped; the next one is taken back in IDLE.
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    // ERR occupies the slot ACCESS would take, without a strobe,
                    // so the error pulse appears in DONE two cycles after the request.
                    done    <= 1'b1;
                    err     <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction field decode for the control unit.
    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign jaddr  = ir[25:0];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (MEM_LATENCY 2, 1, 5) share the
// request inputs, each with its own latency-accurate memory responder. A
// timeline model predicts every output on every cycle; directed sequences
// pin the model with hand-computed values; a random phase follows.
module tb_mem_access_unit;

    localparam logic [31:0] RESET_IR = 32'h2000_0000;
    localparam logic [1:0]  OP_FETCH = 2'b00;
    localparam logic [1:0]  OP_LOAD  = 2'b01;
    localparam logic [1:0]  OP_STORE = 2'b10;
    localparam logic [1:0]  OP_RSVD  = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  op;
    logic        iord;
    logic [31:0] pc, alu_out, wdata;

    logic        busy_w[3], done_w[3], err_w[3], mem_en_w[3], mem_we_w[3];
    logic [31:0] ir_w[3], mdr_w[3], mem_addr_w[3], mem_wdata_w[3], mem_rdata_w[3];
    logic [5:0]  opcode_w[3], funct_w[3];
    logic [4:0]  rs_w[3], rt_w[3], rd_w[3], shamt_w[3];
    logic [15:0] imm_w[3];
    logic [25:0] jaddr_w[3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0109_5020;
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d, cycle %0d]: got %h, expected %h", name, g, cyc, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

            mem_access_unit #(.MEM_LATENCY(L), .RESET_IR(RESET_IR)) u_dut (
                .clock(clock), .reset(reset), .req(req), .op(op), .iord(iord),
                .pc(pc), .alu_out(alu_out), .wdata(wdata),
                .busy(busy_w[g]), .done(done_w[g]), .err(err_w[g]),
                .ir(ir_w[g]), .mdr(mdr_w[g]),
                .opcode(opcode_w[g]), .rs(rs_w[g]), .rt(rt_w[g]), .rd(rd_w[g]),
                .shamt(shamt_w[g]), .funct(funct_w[g]), .imm(imm_w[g]), .jaddr(jaddr_w[g]),
                .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]),
                .mem_addr(mem_addr_w[g]), .mem_wdata(mem_wdata_w[g]),
                .mem_rdata(mem_rdata_w[g])
            );

            // Synchronous memory: read data valid MEM_LATENCY cycles after the strobe cycle, junk otherwise.
            logic [31:0] mem [64];
            logic [3:0]  rd_cnt = '0;
            logic [5:0]  rd_idx = '0;
            logic [31:0] junk   = '0;

            initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);

            always @(posedge clock) begin
                junk <= $urandom;
                if (rd_cnt != 4'd0) rd_cnt <= rd_cnt - 4'd1;
                if (mem_en_w[g]) begin
                    if (mem_we_w[g]) begin
                        mem[mem_addr_w[g][7:2]] = mem_wdata_w[g];
                    end else begin
                        rd_cnt <= 4'(L);
                        rd_idx <= mem_addr_w[g][7:2];
                    end
                end
            end

            assign mem_rdata_w[g] = (rd_cnt == 4'd1) ? mem[rd_idx] : junk;
        end
    endgenerate

    // Timeline model: an accepted request at cycle t gives a strobe at t+1 and done at
    // t+2+latency (t+2 for an illegal request); ir/mdr show the new word from done on.
    logic [31:0] shadow [3][64];
    logic        m_active[3], m_bad[3];
    int          m_tacc[3], m_tdone[3];
    logic [1:0]  m_op[3];
    logic [31:0] m_addr[3], m_wdata[3], m_data[3];
    logic [31:0] m_hold_addr[3], m_hold_wdata[3], m_ir[3], m_mdr[3];

    initial begin
        for (int g = 0; g < 3; g++) begin
            m_active[g] = 1'b0;
            for (int i = 0; i < 64; i++) shadow[g][i] = init_word(i);
        end
    end

    // Single compare process: check every output of every instance each cycle, then advance the model.
    always @(negedge clock) begin : p_compare
        logic        e_done, e_en;
        logic [31:0] e_addr, e_wdata, a_addr;
        for (int g = 0; g < 3; g++) begin
            if (!reset) begin
                m_active[g]     = 1'b0;
                m_ir[g]         = RESET_IR;
                m_mdr[g]        = 32'h0;
                m_hold_addr[g]  = 32'h0;
                m_hold_wdata[g] = 32'h0;
            end else if (m_active[g] && cyc == m_tdone[g] && !m_bad[g]) begin
                if (m_op[g] == OP_FETCH) m_ir[g]  = m_data[g];
                if (m_op[g] == OP_LOAD)  m_mdr[g] = m_data[g];
            end
            e_done  = m_active[g] && (cyc == m_tdone[g]);
            e_en    = m_active[g] && !m_bad[g] && (cyc == m_tacc[g] + 1);
            e_addr  = (m_active[g] && !m_bad[g]) ? m_addr[g]  : m_hold_addr[g];
            e_wdata = (m_active[g] && !m_bad[g]) ? m_wdata[g] : m_hold_wdata[g];
            check("busy",      g, 32'(busy_w[g]),   32'(m_active[g]));
            check("done",      g, 32'(done_w[g]),   32'(e_done));
            check("err",       g, 32'(err_w[g]),    32'(e_done && m_bad[g]));
            check("mem_en",    g, 32'(mem_en_w[g]), 32'(e_en));
            check("mem_we",    g, 32'(mem_we_w[g]), 32'(e_en && m_op[g] == OP_STORE));
            check("mem_addr",  g, mem_addr_w[g],    e_addr);
            check("mem_wdata", g, mem_wdata_w[g],   e_wdata);
            check("ir",        g, ir_w[g],          m_ir[g]);
            check("mdr",       g, mdr_w[g],         m_mdr[g]);
            check("fields",    g, {opcode_w[g], rs_w[g], rt_w[g], rd_w[g], shamt_w[g], funct_w[g]}, m_ir[g]);
            check("imm",       g, 32'(imm_w[g]),    32'(m_ir[g][15:0]));
            check("jaddr",     g, 32'(jaddr_w[g]),  32'(m_ir[g][25:0]));
            if (reset) begin
                if (!m_active[g] && req) begin
                    a_addr       = iord ? alu_out : pc;
                    m_active[g]  = 1'b1;
                    m_bad[g]     = (a_addr[1:0] != 2'b00) || (op == OP_RSVD);
                    m_op[g]      = op;
                    m_addr[g]    = a_addr;
                    m_wdata[g]   = wdata;
                    m_tacc[g]    = cyc;
                    m_tdone[g]   = m_bad[g] ? cyc + 2 : cyc + 2 + lat_of(g);
                    m_data[g]    = shadow[g][a_addr[7:2]];
                    if (!m_bad[g] && op == OP_STORE) shadow[g][a_addr[7:2]] = wdata;
                end else if (m_active[g] && cyc == m_tdone[g]) begin
                    m_active[g] = 1'b0;
                    if (!m_bad[g]) begin
                        m_hold_addr[g]  = m_addr[g];
                        m_hold_wdata[g] = m_wdata[g];
                    end
                end
            end
        end
    end

    // Per-instance observations over a bounded window.
    int          lat[3], n_en[3], n_done[3], n_err[3];
    logic [31:0] en_addr[3], en_wdata[3];
    logic        en_we[3];

    task automatic issue(input logic [1:0] o, input logic io, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] w, output int t_req);
        @(posedge clock);
        #1;
        req = 1'b1; op = o; iord = io; pc = p; alu_out = a; wdata = w;
        t_req = cyc;
        @(posedge clock);
        #1;
        req = 1'b0;
    endtask

    task automatic observe(input int t_req, input int ncyc);
        for (int g = 0; g < 3; g++) begin
            lat[g] = -1; n_en[g] = 0; n_done[g] = 0; n_err[g] = 0;
            en_addr[g] = 32'h0; en_wdata[g] = 32'h0; en_we[g] = 1'b0;
        end
        repeat (ncyc) begin
            @(negedge clock);
            for (int g = 0; g < 3; g++) begin
                if (mem_en_w[g]) begin
                    n_en[g]++;
                    en_addr[g] = mem_addr_w[g]; en_wdata[g] = mem_wdata_w[g]; en_we[g] = mem_we_w[g];
                end
                if (done_w[g]) begin
                    n_done[g]++;
                    if (lat[g] < 0) lat[g] = cyc - t_req;
                end
                if (err_w[g]) n_err[g]++;
            end
        end
    endtask

    initial begin : p_stim
        int t;
        reset = 1'b0; req = 1'b0; op = OP_FETCH; iord = 1'b0;
        pc = 32'h0; alu_out = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;

        // Fetch from pc=0x10: add $10,$8,$9.
        issue(OP_FETCH, 1'b0, 32'h10, 32'h0000_0124, 32'h0, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("fetch_latency", g, 32'(lat[g]), 32'(lat_of(g) + 2));
            check("fetch_n_en",    g, 32'(n_en[g]), 32'd1);
            check("fetch_addr",    g, en_addr[g], 32'h10);
            check("fetch_we",      g, 32'(en_we[g]), 32'd0);
            check("fetch_n_done",  g, 32'(n_done[g]), 32'd1);
            check("fetch_opcode",  g, 32'(opcode_w[g]), 32'd0);
            check("fetch_funct",   g, 32'(funct_w[g]), 32'h20);
            check("fetch_rs",      g, 32'(rs_w[g]), 32'd8);
            check("fetch_rt",      g, 32'(rt_w[g]), 32'd9);
            check("fetch_rd",      g, 32'(rd_w[g]), 32'd10);
            check("fetch_mdr",     g, mdr_w[g], 32'h0);
        end

        // Mid-cycle reset from a non-reset state, then idle cycles.
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_ir",       g, ir_w[g], RESET_IR);
            check("rst_mem_addr", g, mem_addr_w[g], 32'h0);
            check("rst_outs",     g, 32'({busy_w[g], done_w[g], err_w[g], mem_en_w[g], mem_we_w[g]}), 32'd0);
            check("rst_mdr_wd",   g, mdr_w[g] | mem_wdata_w[g], 32'h0);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        observe(cyc, 10);
        for (int g = 0; g < 3; g++) check("idle_n_en", g, 32'(n_en[g] + n_done[g]), 32'd0);

        // Store then load at 0x40.
        issue(OP_STORE, 1'b1, 32'h0000_0013, 32'h40, 32'hDEAD_BEEF, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("store_we",    g, 32'(en_we[g]), 32'd1);
            check("store_wdata", g, en_wdata[g], 32'hDEAD_BEEF);
            check("store_addr",  g, en_addr[g], 32'h40);
            check("store_lat",   g, 32'(lat[g]), 32'(lat_of(g) + 2));
        end
        issue(OP_LOAD, 1'b1, 32'h0, 32'h40, 32'h1234_5678, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("load_mdr", g, mdr_w[g], 32'hDEAD_BEEF);
            check("load_ir",  g, ir_w[g], RESET_IR);
            check("load_we",  g, 32'(en_we[g]), 32'd0);
        end

        // Misaligned load and reserved op.
        issue(OP_LOAD, 1'b1, 32'h0, 32'h42, 32'h0, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("misal_n_en", g, 32'(n_en[g]), 32'd0);
            check("misal_lat",  g, 32'(lat[g]), 32'd2);
            check("misal_err",  g, 32'(n_err[g]), 32'd1);
            check("misal_mdr",  g, mdr_w[g], 32'hDEAD_BEEF);
        end
        issue(OP_RSVD, 1'b0, 32'h20, 32'h0, 32'h0, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("rsvd_n_en", g, 32'(n_en[g]), 32'd0);
            check("rsvd_lat",  g, 32'(lat[g]), 32'd2);
            check("rsvd_err",  g, 32'(n_err[g]), 32'd1);
        end

        // Request while busy, and pc changed after acceptance.
        issue(OP_FETCH, 1'b0, 32'h10, 32'h0, 32'h0, t);
        fork
            observe(t, 10);
            begin
                @(posedge clock);
                #1 req = 1'b1; pc = 32'h80;
                @(posedge clock);
                #1 req = 1'b0;
            end
        join
        for (int g = 0; g < 3; g++) begin
            check("busy_n_en",   g, 32'(n_en[g]), 32'd1);
            check("busy_addr",   g, en_addr[g], 32'h10);
            check("busy_n_done", g, 32'(n_done[g]), 32'd1);
        end

        // Reset during WAIT of a fetch, then a clean fetch.
        issue(OP_FETCH, 1'b0, 32'h10, 32'h0, 32'h0, t);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rstw_ir",   g, ir_w[g], RESET_IR);
            check("rstw_done", g, 32'({busy_w[g], done_w[g]}), 32'd0);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        observe(cyc, 10);
        for (int g = 0; g < 3; g++) check("rstw_no_done", g, 32'(n_done[g]), 32'd0);
        issue(OP_FETCH, 1'b0, 32'h10, 32'h0, 32'h0, t);
        observe(t, 10);
        for (int g = 0; g < 3; g++) begin
            check("refetch_lat", g, 32'(lat[g]), 32'(lat_of(g) + 2));
            check("refetch_ir",  g, ir_w[g], 32'h0109_5020);
        end

        // Random traffic, checked cycle by cycle by the model.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            @(posedge clock);
            #1;
            req  = ($urandom_range(0, 2) == 0);
            op   = ($urandom_range(0, 7) == 7) ? OP_RSVD : 2'($urandom_range(0, 2));
            iord = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            pc = a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            alu_out = a;
            wdata   = $urandom;
        end
        #1 req = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side sequencer that sits beside the multicycle control unit.
- Takes single-cycle access requests (instruction fetch, data load, data store) and drives a synchronous 32-bit word memory with a fixed read latency.
- Latches fetched words into the instruction register and loaded words into the MDR.
- Decodes the instruction register into the opcode/funct/register fields that the control unit consumes, and returns a one-cycle done pulse so control can leave its wait states.

Parameters:
- MEM_LATENCY, 2: cycles from the mem_en cycle to the cycle in which mem_rdata is valid. Legal range is 1..15.
- RESET_IR, 32'h0000_0000: value loaded into ir on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled only in IDLE.
- op  in  2  access type: 00 FETCH, 01 LOAD, 10 STORE, 11 reserved (treated as error).
- iord  in  1  address select: 0 selects pc, 1 selects alu_out.
- pc  in  32  program counter.
- alu_out  in  32  ALU output register (data address).
- wdata  in  32  store data (B register).
- busy  out  1  high from the cycle after an accepted req until done inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on a misaligned address or reserved op.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- shamt  out  5  ir[10:6].
- funct  out  6  ir[5:0].
- imm  out  16  ir[15:0].
- jaddr  out  26  ir[25:0].
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, valid only with mem_en.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; busy, done, err, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, mdr = 0; ir = RESET_IR.
  - An access in flight is abandoned with no done and no register update.
  - Decoded field outputs are purely combinational from ir.
- FSM states: IDLE, ACCESS, WAIT, DONE, ERR.
- IDLE:
  - On req=1 at a rising edge, capture addr = iord ? alu_out : pc, along with op and wdata.
  - If addr[1:0] != 0 or op == 11, go to ERR. Otherwise go to ACCESS.
  - req=0 keeps the FSM in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we=1 only for STORE; mem_addr/mem_wdata driven from the captured values.
  - Load the latency counter with MEM_LATENCY, then go to WAIT.
- WAIT:
  - mem_en=0 and mem_we=0; mem_addr is held.
  - The counter decrements each cycle. In the cycle in which mem_rdata is valid (MEM_LATENCY cycles after ACCESS), capture mem_rdata at the rising edge:
    - FETCH writes ir only.
    - LOAD writes mdr only.
    - STORE captures nothing.
  - Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. ir/mdr already hold the new value in this cycle.
- ERR: done=1 and err=1 for one cycle; no memory strobe, ir/mdr unchanged; go to IDLE.
- Latency:
  - req accepted at edge ending cycle T.
  - ACCESS in cycle T+1.
  - Data valid in T+1+MEM_LATENCY.
  - done in T+2+MEM_LATENCY, i.e. 4 cycles after req for MEM_LATENCY=2.
  - Next req is accepted no earlier than the cycle after done.
- req while busy is ignored, with no queuing. req asserted in the DONE cycle is also ignored.
- pc/alu_out/wdata/iord changes after acceptance do not affect the access in flight.
- mem_en is high for exactly one cycle per non-error access.

Test Plan:
- Reset then idle: assert reset=0 mid-cycle -> all outputs 0 and ir=RESET_IR immediately; no mem_en for 10 idle cycles.
- Fetch: pc=0x0000_0010, iord=0, op=FETCH, req pulse; memory returns 0x0109_5020 at 0x10 -> mem_en one cycle with mem_addr=0x10, mem_we=0; done 4 cycles after req (MEM_LATENCY=2); opcode=0, funct=0x20, rs=8, rt=9, rd=10; mdr unchanged.
- Load/store: STORE with alu_out=0x40, wdata=0xDEAD_BEEF -> mem_we=1 with mem_wdata=0xDEAD_BEEF. Then LOAD with alu_out=0x40 -> mdr=0xDEAD_BEEF at done; ir unchanged.
- Misaligned: LOAD with alu_out=0x42 -> no mem_en; done=err=1 two cycles after req; mdr unchanged. Same response for op=11.
- Busy/ignore and input change: second req during WAIT, and pc changed to 0x80 after acceptance -> only one mem_en, at the original address; exactly one done.
- Reset mid-operation: assert reset during WAIT of a FETCH -> no done; ir=RESET_IR; a subsequent FETCH completes normally. Repeat the fetch sequence with MEM_LATENCY=1 and MEM_LATENCY=5 and check done at 3 and 7 cycles after req.
